data_memory_unit: RTL and testbench

Data-memory responder on the DM side of the EX/DM pipeline register. It consumes that register's memory-read strobe, memory-write strobe, address and store data. It performs the access against an internal word-addressed RAM with a configurable multi-cycle latency. It stalls the pipeline until the access completes and returns load data with a one-cycle valid pulse.

---
 rtl/data_memory_unit.sv | 107 ++++++++++
 tb/tb_data_memory_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// data_memory_unit: multi-cycle word RAM responder with pipeline stall; optional DMEM_ALIGN_CHECK_EN flags misaligned accesses
module data_memory_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Mem_read_in,
    input  logic        Mem_write_in,
    input  logic [31:0] Mem_address,
    input  logic [31:0] Write_data_in,
    output logic [31:0] Read_data_out,
    output logic        Read_valid_out,
    output logic        Mem_stall_out,
    output logic        Misaligned_out
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic hold_wr;
    logic [ADDR_WIDTH-1:0] hold_idx;
    logic [31:0] hold_data;
    logic req, access, stall, cur_wr, mis;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [31:0] cur_data;
    assign req = Mem_read_in | Mem_write_in;
    assign cur_wr = state == IDLE ? Mem_write_in : hold_wr;
    assign cur_idx = state == IDLE ? Mem_address[ADDR_WIDTH+1:2] : hold_idx;
    assign cur_data = state == IDLE ? Write_data_in : hold_data;
    assign Mem_stall_out = rst ? 1'b0 : stall;
`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] hold_lo;
    logic unused_addr;
    assign unused_addr = ^Mem_address[31:ADDR_WIDTH+2];
    assign mis = |(state == IDLE ? Mem_address[1:0] : hold_lo);
    // low address bits are kept so the alignment decision survives the busy wait
    always_ff @(posedge clk)
        if (!rst && state == IDLE && req) hold_lo <= Mem_address[1:0];
`else
    logic unused_addr;
    assign unused_addr = ^{Mem_address[31:ADDR_WIDTH+2], Mem_address[1:0]};
    assign mis = 1'b0;
`endif
    // next state, latency countdown and stall; the access fires on the last countdown edge
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        access = 1'b0;
        stall = 1'b0;
        case (state)
            IDLE: begin
                stall = req;
                if (req) begin
                    if (LATENCY == 1) begin
                        access = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt > 4'd1) cnt_nxt = cnt - 4'd1;
                else begin
                    access = 1'b1;
                    cnt_nxt = 4'd0;
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // state register; reset aborts any transaction in flight
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
    // capture the request when accepted so later input changes do not matter
    always_ff @(posedge clk)
        if (!rst && state == IDLE && req) begin
            hold_wr <= Mem_write_in;
            hold_idx <= Mem_address[ADDR_WIDTH+1:2];
            hold_data <= Write_data_in;
        end
    // array write on the access edge; contents survive reset
    always_ff @(posedge clk)
        if (!rst && access && cur_wr && !mis) mem[cur_idx] <= cur_data;
    // registered load data, valid pulse and alignment pulse for the DONE cycle
    always_ff @(posedge clk)
        if (rst) begin
            Read_data_out <= 32'h0;
            Read_valid_out <= 1'b0;
            Misaligned_out <= 1'b0;
        end else begin
            Read_valid_out <= access && !cur_wr && !mis;
            Misaligned_out <= access && mis;
            if (access && !cur_wr) Read_data_out <= mis ? 32'h0 : mem[cur_idx];
        end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: scoreboard bench for data_memory_unit
module tb_data_memory_unit;
    localparam int AW = 10;
    localparam int LAT = 2;
    logic clk = 0, rst = 1, rd = 0, wr = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] rdata;
    logic valid, stall, mis;
    int tests = 0, fails = 0;
    logic [31:0] sbq[$];
    logic [31:0] model [int];

    data_memory_unit #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .Mem_read_in(rd), .Mem_write_in(wr),
        .Mem_address(addr), .Write_data_in(wdata), .Read_data_out(rdata),
        .Read_valid_out(valid), .Mem_stall_out(stall), .Misaligned_out(mis)
    );

    always #5 clk = ~clk;

    // every valid pulse must match the oldest expected load
    always @(negedge clk)
        if (valid) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_valid: got valid with data %h, required no valid", rdata);
            end else begin
                logic [31:0] e;
                e = sbq.pop_front();
                if (rdata !== e) begin
                    fails++;
                    $display("FAIL sb_data: got %h, required %h", rdata, e);
                end
            end
        end

    task automatic do_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic v, output logic m, output logic [31:0] q);
        int idx;
        bit ok;
        idx = int'(a[AW+1:2]);
`ifdef DMEM_ALIGN_CHECK_EN
        ok = a[1:0] == 2'b00;
`else
        ok = 1'b1;
`endif
        stalls = 0;
        rd = r; wr = w; addr = a; wdata = d;
        if (w && ok) model[idx] = d;
        else if (r && !w && ok) sbq.push_back(model.exists(idx) ? model[idx] : 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
        end
        if (stalls >= 19) begin
            tests++; fails++;
            $display("FAIL txn_timeout: stall still high after %0d cycles, required %0d", stalls, LAT);
        end
        v = valid; m = mis; q = rdata;
        @(posedge clk); #1;
        rd = 0; wr = 0;
    endtask

    task automatic test_reset();
        rd = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({stall, valid, mis, rdata} !== 35'h0) begin
            fails++;
            $display("FAIL reset_outputs: stall=%b valid=%b mis=%b data=%h, required all 0", stall, valid, mis, rdata);
        end
        @(posedge clk); #1;
        rst = 0; rd = 0;
        @(negedge clk);
        tests++;
        if (stall !== 1'b0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: stall=%b valid=%b, required 0 0", stall, valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int s; logic v, m; logic [31:0] q, prev;
        do_txn(0, 1, 32'h10, 32'hDEADBEEF, s, v, m, q);
        tests++;
        if (s != LAT || v !== 1'b0) begin
            fails++;
            $display("FAIL store_timing: stalls=%0d valid=%b, required %0d 0", s, v, LAT);
        end
        do_txn(1, 0, 32'h10, 32'h0, s, v, m, q);
        tests++;
        if (s != LAT || v !== 1'b1 || q !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL load_result: stalls=%0d valid=%b data=%h, required %0d 1 deadbeef", s, v, q, LAT);
        end
        prev = q;
        @(negedge clk);
        tests++;
        if (valid !== 1'b0 || rdata !== prev) begin
            fails++;
            $display("FAIL load_hold: valid=%b data=%h, required 0 %h", valid, rdata, prev);
        end
        @(posedge clk); #1;
        do_txn(0, 1, 32'h14, 32'h55, s, v, m, q);
        tests++;
        if (q !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL data_hold_over_write: data=%h, required deadbeef", q);
        end
    endtask

    task automatic test_simultaneous();
        int s; logic v, m; logic [31:0] q;
        do_txn(1, 1, 32'h20, 32'h12345678, s, v, m, q);
        tests++;
        if (v !== 1'b0 || s != LAT) begin
            fails++;
            $display("FAIL both_strobes: valid=%b stalls=%0d, required 0 %0d", v, s, LAT);
        end
        do_txn(1, 0, 32'h20, 32'h0, s, v, m, q);
        tests++;
        if (v !== 1'b1 || q !== 32'h12345678) begin
            fails++;
            $display("FAIL both_strobes_read: valid=%b data=%h, required 1 12345678", v, q);
        end
    endtask

    task automatic test_wrap();
        int s; logic v, m; logic [31:0] q;
        do_txn(0, 1, 32'h1004, 32'hA5A5A5A5, s, v, m, q);
        do_txn(1, 0, 32'h0004, 32'h0, s, v, m, q);
        tests++;
        if (q !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL wrap: data=%h, required a5a5a5a5", q);
        end
    endtask

    task automatic test_reset_mid_write();
        int s; logic v, m; logic [31:0] q;
        do_txn(0, 1, 32'h40, 32'h0, s, v, m, q);
        wr = 1; addr = 32'h40; wdata = 32'h1;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL stall_in_reset: stall=%b, required 0", stall);
        end
        @(posedge clk); #1;
        rst = 0; wr = 0;
        repeat (3) @(negedge clk);
        tests++;
        if (valid !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet: valid=%b stall=%b, required 0 0", valid, stall);
        end
        @(posedge clk); #1;
        do_txn(1, 0, 32'h40, 32'h0, s, v, m, q);
        tests++;
        if (q !== 32'h0) begin
            fails++;
            $display("FAIL aborted_write: data=%h, required 0", q);
        end
    endtask

    task automatic test_flush();
        int s; logic v;
        do_txn(0, 1, 32'h80, 32'hCAFEF00D, s, v, v, wdata);
        rd = 1; addr = 32'h80;
        sbq.push_back(32'hCAFEF00D);
        @(posedge clk); #1;
        rd = 0; addr = 32'h0;
        v = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid) begin v = 1; break; end
        end
        tests++;
        if (v !== 1'b1 || rdata !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL flush_completes: valid=%b data=%h, required 1 cafef00d", v, rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int s1, s2; logic v1, v2, m; logic [31:0] q1, q2;
        do_txn(0, 1, 32'h100, 32'h11111111, s1, v1, m, q1);
        do_txn(0, 1, 32'h104, 32'h22222222, s2, v2, m, q2);
        do_txn(1, 0, 32'h100, 32'h0, s1, v1, m, q1);
        do_txn(1, 0, 32'h104, 32'h0, s2, v2, m, q2);
        tests++;
        if (s1 != LAT || s2 != LAT || q1 !== 32'h11111111 || q2 !== 32'h22222222 || v1 !== 1'b1 || v2 !== 1'b1) begin
            fails++;
            $display("FAIL back_to_back: stalls=%0d/%0d data=%h/%h, required %0d/%0d 11111111/22222222", s1, s2, q1, q2, LAT, LAT);
        end
    endtask

    task automatic test_align();
        int s; logic v, m; logic [31:0] q;
        do_txn(0, 1, 32'h40, 32'h0, s, v, m, q);
        do_txn(0, 1, 32'h42, 32'h77, s, v, m, q);
`ifdef DMEM_ALIGN_CHECK_EN
        tests++;
        if (m !== 1'b1 || s != LAT) begin
            fails++;
            $display("FAIL misaligned_flag: mis=%b stalls=%0d, required 1 %0d", m, s, LAT);
        end
        do_txn(1, 0, 32'h40, 32'h0, s, v, m, q);
        tests++;
        if (q !== 32'h0 || m !== 1'b0) begin
            fails++;
            $display("FAIL misaligned_write_dropped: data=%h mis=%b, required 0 0", q, m);
        end
        do_txn(1, 0, 32'h43, 32'h0, s, v, m, q);
        tests++;
        if (v !== 1'b0 || m !== 1'b1 || q !== 32'h0) begin
            fails++;
            $display("FAIL misaligned_read: valid=%b mis=%b data=%h, required 0 1 0", v, m, q);
        end
`else
        tests++;
        if (m !== 1'b0) begin
            fails++;
            $display("FAIL misaligned_tied: mis=%b, required 0", m);
        end
        do_txn(1, 0, 32'h40, 32'h0, s, v, m, q);
        tests++;
        if (q !== 32'h77) begin
            fails++;
            $display("FAIL unaligned_ignored: data=%h, required 77", q);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_simultaneous();
        test_wrap();
        test_reset_mid_write();
        test_flush();
        test_back_to_back();
        test_align();
        repeat (4) @(negedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d loads never returned, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
